stc0_spram_arbiter: RTL and testbench
=====================================

# stc0_spram_arbiter

Two-requester arbiter and sequencer for the single-port twiddle SRAM (`spram`, 1024×32) attached to a butterfly stage. It shares the macro between the butterfly's twiddle-read stream and the host path (control-register loads/readback from the ingress command processor). It registers every SRAM command and returns tagged read data to the correct requester. Butterfly reads have priority; a starvation counter guarantees host progress.

## Interface
- `DW`, 32, SRAM data width (packed re/im twiddle, 2×16)
- `AW`, 10, SRAM address width
- `RD_LAT`, 1, SRAM read latency in clocks (command edge to valid `SramRData`)
- `MAX_WAIT`, 4, max consecutive cycles a pending host request may lose before forced grant (1..15)

Ports:
- `Clk`  in  1  single clock for all logic and the SRAM
- `ARst`  in  1  asynchronous, active-high reset
- `BfReq`  in  1  butterfly read request, level; one read per cycle while high and granted
- `BfAddr`  in  AW  butterfly read address
- `BfGnt`  out  1  butterfly request accepted this cycle (combinational)
- `BfRData`  out  DW  butterfly read data
- `BfRValid`  out  1  `BfRData` valid, one pulse per accepted read
- `HReq`  in  1  host request, held until `HGnt`
- `HWe`  in  1  1 = write, 0 = read
- `HAddr`  in  AW  host address
- `HWData`  in  DW  host write data
- `HGnt`  out  1  host request accepted this cycle (combinational)
- `HRData`  out  DW  host read data
- `HRValid`  out  1  `HRData` valid
- `SramCsn`  out  1  SRAM chip select, active low, registered
- `SramWen`  out  1  SRAM write enable, active low, registered
- `SramAddr`  out  AW  registered
- `SramWData`  out  DW  registered
- `SramRData`  in  DW  SRAM read data

## Operation
- Arbitration, per cycle:
  - If only one side requests, that side is granted.
  - If both request, butterfly wins unless `wait_cnt == MAX_WAIT`; then host wins.
- `wait_cnt` (4-bit):
  - Increments when `HReq && !HGnt`.
  - Clears on `HGnt` or when `HReq` is low.
  - Saturates at `MAX_WAIT`.
- Accepted request → next edge loads the SRAM command registers:
  - `SramCsn` = 0.
  - `SramWen` = !`HWe` for host; 1 for butterfly.
  - Addr and data copied from the granted requester.
  - With no grant: `SramCsn` = 1; `SramWen`, `SramAddr`, `SramWData` hold their previous values.
- Read tag shift register, length `RD_LAT`+1, entries {valid, owner}, pushed at grant. Host writes push invalid.
- At the tail: valid entry → pulse `BfRValid` or `HRValid` for one cycle. Both RData outputs are driven directly from `SramRData` (no mux register).
- Host write completes at the command edge with no response. A read to the same address issued later always returns the new data (the SRAM is strictly in order).
- Reset mid-operation:
  - Tags clear; in-flight reads are dropped with no RValid.
  - `SramCsn` is forced to 1 asynchronously.
  - Requesters re-issue.

## Timing
- Reset values:
  - `SramCsn`=1, `SramWen`=1, `SramAddr`=0, `SramWData`=0.
  - `BfRValid`=0, `HRValid`=0, `wait_cnt`=0, all tags invalid.
  - `BfGnt`/`HGnt` follow requests combinationally but are 0 during `ARst`.
- Read latency, grant cycle N:
  - Command on SRAM pins in N+1.
  - Data plus RValid in N+1+`RD_LAT` (N+2 at default).
- Throughput: one access per cycle. A continuous `BfReq` sustains 1 read/clk except for the forced host slot: at most one stolen cycle per `MAX_WAIT`+1.
- `BfReq` continuously high with `HReq` high: host granted on the (`MAX_WAIT`+1)th cycle of waiting; `BfGnt`=0 that cycle only.
- `HReq` deasserted before grant: no access; counter clears.
- Simultaneous `HRValid` and `BfRValid` are impossible (one access per cycle).

## Structure
- Shared package / `stc0_addrMap.vh`: the owner-encoding constants `OWN_BF`=0 and `OWN_HOST`=1.
- One natural sub-module: `stc0_rdtag_pipe`, a parameterised {valid, owner} shift register of depth `RD_LAT`+1 with async clear.
- The arbiter is a single flat always block plus combinational grant logic.

## Test plan
- Host write A=0x005, D=0x1234_ABCD, then host read 0x005 → `HRValid` 2 cycles after the read grant, `HRData`=0x1234_ABCD; `SramWen`=0 exactly once.
- `BfReq` held 20 cycles, addresses 0..19 pre-loaded with i*3 → 20 `BfRValid` pulses, each 2 cycles after its grant, data i*3, no gaps.
- `BfReq` continuous plus host read pending, `MAX_WAIT`=4 → host granted on the 5th waiting cycle; one `BfGnt`=0 bubble; `wait_cnt` back to 0.
- Both request in the cycle after `ARst` release with `wait_cnt`=0 → butterfly granted first.
- `ARst` pulsed while 2 butterfly reads are in flight → no `BfRValid`; `SramCsn`=1 immediately; after release, a fresh read returns correct data.
- `HReq` raised 2 cycles, dropped before grant under butterfly load → no host SRAM access, `HRValid` never asserted.

Source files
------------

// File: rtl/stc0_spram_arbiter_pkg.sv
// Shared types for the twiddle SRAM arbiter: read-tag owner encoding and tag record.
package stc0_spram_arbiter_pkg;

  localparam logic OWN_BF   = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef struct packed {
    logic vld;
    logic owner;
  } tag_t;

endpackage

// File: rtl/stc0_rdtag_pipe.sv
// {valid, owner} delay line matching the SRAM read latency; tail lines up with SRAM read data.
module stc0_rdtag_pipe
  import stc0_spram_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t push,
  output tag_t tail
);

  tag_t stages [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= push;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tail = stages[DEPTH-1];

endmodule

// File: rtl/stc0_spram_arbiter.sv
// Shares the single-port twiddle SRAM between butterfly reads (priority) and the host path,
// with a starvation counter that forces a host slot after MAX_WAIT lost cycles.
module stc0_spram_arbiter
  import stc0_spram_arbiter_pkg::*;
#(
  parameter int DW       = 32,
  parameter int AW       = 10,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          Clk,
  input  logic          ARst,
  input  logic          BfReq,
  input  logic [AW-1:0] BfAddr,
  output logic          BfGnt,
  output logic [DW-1:0] BfRData,
  output logic          BfRValid,
  input  logic          HReq,
  input  logic          HWe,
  input  logic [AW-1:0] HAddr,
  input  logic [DW-1:0] HWData,
  output logic          HGnt,
  output logic [DW-1:0] HRData,
  output logic          HRValid,
  output logic          SramCsn,
  output logic          SramWen,
  output logic [AW-1:0] SramAddr,
  output logic [DW-1:0] SramWData,
  input  logic [DW-1:0] SramRData
);

  logic [3:0] wait_cnt;
  logic       host_forced;
  tag_t       push_tag;
  tag_t       tail_tag;

  // Grants are masked during reset so nothing is accepted that the cleared tags would lose.
  always_comb begin
    host_forced = (wait_cnt == 4'(MAX_WAIT));
    BfGnt       = BfReq && !ARst && !(HReq && host_forced);
    HGnt        = HReq && !ARst && (!BfReq || host_forced);
  end

  always_ff @(posedge Clk or posedge ARst) begin
    if (ARst) begin
      wait_cnt  <= '0;
      SramCsn   <= 1'b1;
      SramWen   <= 1'b1;
      SramAddr  <= '0;
      SramWData <= '0;
    end else begin
      if (HGnt || !HReq)
        wait_cnt <= '0;
      else if (!host_forced)
        wait_cnt <= wait_cnt + 4'd1;

      if (HGnt) begin
        SramCsn   <= 1'b0;
        SramWen   <= !HWe;
        SramAddr  <= HAddr;
        SramWData <= HWData;
      end else if (BfGnt) begin
        SramCsn   <= 1'b0;
        SramWen   <= 1'b1;
        SramAddr  <= BfAddr;
      end else begin
        SramCsn   <= 1'b1;
      end
    end
  end

  // Host writes carry no response, so they enter the tag pipe as bubbles.
  always_comb begin
    push_tag.vld   = BfGnt || (HGnt && !HWe);
    push_tag.owner = HGnt ? OWN_HOST : OWN_BF;
  end

  stc0_rdtag_pipe #(
    .DEPTH(RD_LAT + 1)
  ) u_rdtag_pipe (
    .clk (Clk),
    .rst (ARst),
    .push(push_tag),
    .tail(tail_tag)
  );

  assign BfRValid = tail_tag.vld && (tail_tag.owner == OWN_BF);
  assign HRValid  = tail_tag.vld && (tail_tag.owner == OWN_HOST);
  assign BfRData  = SramRData;
  assign HRData   = SramRData;

endmodule

// File: tb/tb_stc0_spram_arbiter.sv
// Bench for stc0_spram_arbiter: vector table plus scoreboard of expected read data and arrival cycle.
module tb_stc0_spram_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int RD_LAT = 1;
  localparam int MAX_WAIT = 4;

  logic          Clk = 1'b0;
  logic          ARst;
  logic          BfReq;
  logic [AW-1:0] BfAddr;
  logic          BfGnt;
  logic [DW-1:0] BfRData;
  logic          BfRValid;
  logic          HReq;
  logic          HWe;
  logic [AW-1:0] HAddr;
  logic [DW-1:0] HWData;
  logic          HGnt;
  logic [DW-1:0] HRData;
  logic          HRValid;
  logic          SramCsn;
  logic          SramWen;
  logic [AW-1:0] SramAddr;
  logic [DW-1:0] SramWData;
  logic [DW-1:0] SramRData;

  stc0_spram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
    .Clk(Clk), .ARst(ARst),
    .BfReq(BfReq), .BfAddr(BfAddr), .BfGnt(BfGnt), .BfRData(BfRData), .BfRValid(BfRValid),
    .HReq(HReq), .HWe(HWe), .HAddr(HAddr), .HWData(HWData), .HGnt(HGnt),
    .HRData(HRData), .HRValid(HRValid),
    .SramCsn(SramCsn), .SramWen(SramWen), .SramAddr(SramAddr), .SramWData(SramWData),
    .SramRData(SramRData)
  );

  always #5 Clk = ~Clk;

  // Behavioural 1024x32 single-port SRAM, one-cycle read latency.
  logic [DW-1:0] mem [1024] = '{default: '0};
  int            wr_cnt = 0;
  always @(posedge Clk) begin
    if (!SramCsn) begin
      if (!SramWen) begin
        mem[SramAddr] <= SramWData;
        wr_cnt <= wr_cnt + 1;
      end else begin
        SramRData <= mem[SramAddr];
      end
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  typedef struct {
    logic          breq;
    logic [AW-1:0] baddr;
    logic          hreq;
    logic          hwe;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hwd;
    logic          exp_bg;
    logic          exp_hg;
  } vec_t;

  exp_t          bf_q[$];
  exp_t          h_q[$];
  logic [DW-1:0] ref_mem [1024] = '{default: '0};
  int            cyc = 0;
  int            n_pass = 0;
  int            n_total = 0;
  int            bf_seen = 0;
  int            h_seen = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic drive(input logic breq, input logic [AW-1:0] baddr, input logic hreq,
                       input logic hwe, input logic [AW-1:0] haddr, input logic [DW-1:0] hwd);
    BfReq = breq; BfAddr = baddr; HReq = hreq; HWe = hwe; HAddr = haddr; HWData = hwd;
  endtask

  // One clock: sample at the falling edge, score returning data, log new grants, advance.
  task automatic tick(output logic bg, output logic hg);
    exp_t e;
    @(negedge Clk);
    bg = BfGnt;
    hg = HGnt;
    if (BfRValid && HRValid) chk("both_rvalid", {31'd0, HRValid}, 32'd0);
    if (BfRValid) begin
      bf_seen++;
      if (bf_q.size() == 0) chk("bf_unexpected_rvalid", {31'd0, BfRValid}, 32'd0);
      else begin
        e = bf_q.pop_front();
        chk("bf_rdata", BfRData, e.data);
        chk("bf_rlat", cyc, e.due);
      end
    end
    if (HRValid) begin
      h_seen++;
      if (h_q.size() == 0) chk("h_unexpected_rvalid", {31'd0, HRValid}, 32'd0);
      else begin
        e = h_q.pop_front();
        chk("h_rdata", HRData, e.data);
        chk("h_rlat", cyc, e.due);
      end
    end
    if (bg) bf_q.push_back('{ref_mem[BfAddr], cyc + 1 + RD_LAT});
    if (hg) begin
      if (HWe) ref_mem[HAddr] = HWData;
      else h_q.push_back('{ref_mem[HAddr], cyc + 1 + RD_LAT});
    end
    @(posedge Clk);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [8];
    logic bg, hg;
    int   wr_snap, seen_snap;

    vecs[0] = '{1'b1, 10'd7, 1'b1, 1'b0, 10'd5, 32'd0,          1'b1, 1'b0};
    vecs[1] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0,          1'b0, 1'b1};
    vecs[2] = '{1'b0, 10'd0, 1'b1, 1'b1, 10'd5, 32'h1234_ABCD,  1'b0, 1'b1};
    vecs[3] = '{1'b0, 10'd0, 1'b1, 1'b0, 10'd5, 32'd0,          1'b0, 1'b1};
    vecs[4] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,          1'b0, 1'b0};
    vecs[5] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,          1'b0, 1'b0};
    vecs[6] = '{1'b1, 10'd5, 1'b0, 1'b0, 10'd0, 32'd0,          1'b1, 1'b0};
    vecs[7] = '{1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0,          1'b0, 1'b0};

    // Reset with both requesters active: grants must stay low, registers at reset values.
    ARst = 1'b1;
    drive(1'b1, 10'd1, 1'b1, 1'b1, 10'd2, 32'hDEAD_BEEF);
    tick(bg, hg);
    chk("rst_bf_gnt", {31'd0, bg}, 32'd0);
    chk("rst_h_gnt", {31'd0, hg}, 32'd0);
    tick(bg, hg);
    chk("rst_csn", {31'd0, SramCsn}, 32'd1);
    chk("rst_wen", {31'd0, SramWen}, 32'd1);
    chk("rst_addr", {22'd0, SramAddr}, 32'd0);
    chk("rst_wdata", SramWData, 32'd0);
    chk("rst_bf_rvalid", {31'd0, BfRValid}, 32'd0);
    chk("rst_h_rvalid", {31'd0, HRValid}, 32'd0);
    chk("rst_wait_cnt", {28'd0, dut.wait_cnt}, 32'd0);

    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    ARst = 1'b0;
    wr_snap = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].breq, vecs[i].baddr, vecs[i].hreq, vecs[i].hwe, vecs[i].haddr, vecs[i].hwd);
      tick(bg, hg);
      chk($sformatf("vec%0d_bf_gnt", i), {31'd0, bg}, {31'd0, vecs[i].exp_bg});
      chk($sformatf("vec%0d_h_gnt", i), {31'd0, hg}, {31'd0, vecs[i].exp_hg});
    end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(bg, hg);
    tick(bg, hg);
    chk("single_write_strobe", wr_cnt - wr_snap, 32'd1);
    chk("h_q_drained", h_q.size(), 32'd0);

    // Preload 0..19 with i*3 through host writes, then a 20-cycle butterfly burst.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 10'd0, 1'b1, 1'b1, AW'(i), DW'(i * 3));
      tick(bg, hg);
      chk("preload_h_gnt", {31'd0, hg}, 32'd1);
    end
    seen_snap = bf_seen;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, AW'(i), 1'b0, 1'b0, 10'd0, 32'd0);
      tick(bg, hg);
      chk("burst_bf_gnt", {31'd0, bg}, 32'd1);
    end
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick(bg, hg);
    chk("burst_pulses", bf_seen - seen_snap, 32'd20);

    // Starvation: host read pending under continuous butterfly load wins on its 5th waiting cycle.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, AW'(k), (k <= MAX_WAIT + 1), 1'b0, 10'd3, 32'd0);
      tick(bg, hg);
      chk($sformatf("starve%0d_h_gnt", k), {31'd0, hg}, {31'd0, k == MAX_WAIT + 1});
      chk($sformatf("starve%0d_bf_gnt", k), {31'd0, bg}, {31'd0, k != MAX_WAIT + 1});
      if (k == MAX_WAIT) chk("starve_wait_cnt_sat", {28'd0, dut.wait_cnt}, MAX_WAIT);
    end
    chk("starve_wait_cnt_clear", {28'd0, dut.wait_cnt}, 32'd0);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick(bg, hg);

    // Reset while two butterfly reads are in flight: both dropped, chip select released at once.
    drive(1'b1, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(bg, hg);
    drive(1'b1, 10'd1, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(bg, hg);
    chk("inflight_second_gnt", {31'd0, bg}, 32'd1);
    ARst = 1'b1;
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    #1;
    chk("arst_csn_immediate", {31'd0, SramCsn}, 32'd1);
    bf_q.delete();
    seen_snap = bf_seen;
    tick(bg, hg);
    tick(bg, hg);
    ARst = 1'b0;
    for (int i = 0; i < 3; i++) tick(bg, hg);
    chk("arst_reads_dropped", bf_seen - seen_snap, 32'd0);
    drive(1'b1, 10'd10, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(bg, hg);
    chk("post_rst_bf_gnt", {31'd0, bg}, 32'd1);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick(bg, hg);
    chk("post_rst_read_returned", bf_seen - seen_snap, 32'd1);

    // Host request withdrawn before winning: no access, counter cleared.
    seen_snap = h_seen;
    wr_snap = wr_cnt;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, AW'(k), 1'b1, 1'b1, 10'd4, 32'h5555_AAAA);
      tick(bg, hg);
      chk("withdraw_h_gnt", {31'd0, hg}, 32'd0);
    end
    drive(1'b1, 10'd2, 1'b0, 1'b0, 10'd0, 32'd0);
    tick(bg, hg);
    chk("withdraw_wait_cnt", {28'd0, dut.wait_cnt}, 32'd0);
    drive(1'b0, 10'd0, 1'b0, 1'b0, 10'd0, 32'd0);
    for (int i = 0; i < 3; i++) tick(bg, hg);
    chk("withdraw_no_write", wr_cnt - wr_snap, 32'd0);
    chk("withdraw_no_hrvalid", h_seen - seen_snap, 32'd0);

    chk("final_bf_q_empty", bf_q.size(), 32'd0);
    chk("final_h_q_empty", h_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
